ipsl_pcie_apb_arb_v1_0: RTL and testbench
=========================================

// Module: ipsl_pcie_apb_arb_v1_0
// PURPOSE
//   Single-clock N-master to 1-slave APB arbiter/bridge for the PCIe APB management path.
//   Round-robin arbitrates NUM_MST sel/ce/rdy-style masters onto one slave port.
//   Parametrised widths; bus-hang timeout completes a stuck access with ERR_DATA.
//   Sits between local APB masters (DMA cfg, debug, host-cfg) and the PCIe core APB or cross bridge.
// PARAMETERS
//   NUM_MST   2             number of masters, 1..8
//   ADDR_W    16            APB address width
//   DATA_W    32            APB data width, multiple of 8; strobe width STRB_W = DATA_W/8
//   TIMEOUT   255           max ACCESS cycles before forced completion; 0 = timeout disabled
//   ERR_DATA  {DATA_W{1'b1}} read data returned on timeout
// PORTS
//   i_clk          in   1               clock
//   i_rst_n        in   1               reset; synchronous, active-low
//   i_m_p_sel      in   NUM_MST         per-master select (request)
//   i_m_p_strb     in   NUM_MST*STRB_W  per-master byte strobes, master k at [k*STRB_W +: STRB_W]
//   i_m_p_addr     in   NUM_MST*ADDR_W  per-master address
//   i_m_p_wdata    in   NUM_MST*DATA_W  per-master write data
//   i_m_p_ce       in   NUM_MST         per-master enable (access phase)
//   i_m_p_we       in   NUM_MST         per-master write(1)/read(0)
//   o_m_p_rdy      out  NUM_MST         per-master one-cycle completion pulse
//   o_m_p_rdata    out  NUM_MST*DATA_W  per-master read data, valid while o_m_p_rdy[k]
//   o_s_p_sel/strb/addr/wdata/ce/we  out 1/STRB_W/ADDR_W/DATA_W/1/1  slave-side request
//   i_s_p_rdy      in   1               slave completion
//   i_s_p_rdata    in   DATA_W          slave read data, sampled with i_s_p_rdy
//   o_grant        out  NUM_MST         one-hot owner of the current transfer, 0 when idle
//   o_timeout      out  1               one-cycle pulse on forced completion
// BEHAVIOUR
//   - Reset (i_rst_n=0 at an edge): all outputs 0, FSM IDLE, counter 0, rr pointer = NUM_MST-1 (master 0 wins
//     first). Reset mid-transfer aborts it: o_s_p_sel/ce drop next edge, no o_m_p_rdy issued.
//   - FSM IDLE->SETUP->ACCESS->RESP->IDLE; all outputs registered.
//   - IDLE: request vector = i_m_p_sel. If nonzero, grant first requester searching from ptr+1 upward, modulo
//     NUM_MST; latch that master's strb/addr/wdata/we onto o_s_*, o_s_p_sel<=1, o_grant<=onehot, ptr<=winner; ->SETUP.
//   - SETUP: o_s_p_ce<=1, counter<=0; ->ACCESS.
//   - ACCESS: on i_s_p_rdy=1: o_s_p_sel,o_s_p_ce<=0; o_m_p_rdy[g]<=1; o_m_p_rdata[g]<=we?0:i_s_p_rdata; ->RESP.
//     Else if TIMEOUT!=0 and counter==TIMEOUT-1: same completion but rdata<=we?0:ERR_DATA, o_timeout<=1; ->RESP.
//     Else counter+1. Slave rdy wins over timeout on the same cycle.
//   - RESP: o_m_p_rdy, o_m_p_rdata[g], o_timeout, o_grant cleared to 0 at the next edge; ->IDLE.
//   - Master contract: sel/ce stay stable from request until rdy; sel low at the edge after the rdy cycle.
//     A sel still high in IDLE is a new request.
//   - Latency: sel sampled at edge 0 -> o_s_p_sel after 0, o_s_p_ce after 1; slave rdy sampled at edge M ->
//     o_m_p_rdy high for exactly cycle M+1. Minimum 3 edges from request to rdy.
//   - i_s_p_rdy outside ACCESS is ignored. Non-granted masters' inputs ignored; their rdy/rdata stay 0.
//   - Counter width $clog2(TIMEOUT+1); never wraps (stops at compare). One transfer in flight, no pipelining.
// TESTING
//   1 Single write, m0 addr 16'h0010 wdata 32'h1234_5678 strb 4'hF, slave rdy at 2nd ACCESS cycle ->
//     o_s_p_* match, o_m_p_rdy[0] one cycle, rdata 0.
//   2 Read m1 addr 16'h0020, slave rdata 32'hCAFE_0001 -> o_m_p_rdata[1]=32'hCAFE_0001 with rdy[1]; rdata[0]=0.
//   3 m0,m1 request simultaneously and keep re-requesting 4 transfers -> grants 0,1,0,1; o_grant one-hot.
//   4 TIMEOUT=8, read, slave never rdy -> rdy 8 cycles after ce, rdata 32'hFFFF_FFFF, o_timeout one pulse.
//   5 Slave rdy on the same cycle as timeout compare -> slave data returned, o_timeout stays 0.
//   6 i_rst_n low during ACCESS -> next edge all outputs 0, no rdy; after release m0 granted first.

Source files
------------

// File: rtl/ipsl_pcie_apb_arb_v1_0.sv
// Round-robin arbiter/bridge: NUM_MST APB-style masters onto one APB slave,
// with an optional bus-hang timeout that completes a stuck access with ERR_DATA.
module ipsl_pcie_apb_arb_v1_0 #(
    parameter int                NUM_MST  = 2,
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = {DATA_W{1'b1}}
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_MST-1:0]             i_m_p_sel,
    input  logic [NUM_MST*(DATA_W/8)-1:0]  i_m_p_strb,
    input  logic [NUM_MST*ADDR_W-1:0]      i_m_p_addr,
    input  logic [NUM_MST*DATA_W-1:0]      i_m_p_wdata,
    input  logic [NUM_MST-1:0]             i_m_p_ce,
    input  logic [NUM_MST-1:0]             i_m_p_we,
    output logic [NUM_MST-1:0]             o_m_p_rdy,
    output logic [NUM_MST*DATA_W-1:0]      o_m_p_rdata,
    output logic                           o_s_p_sel,
    output logic [DATA_W/8-1:0]            o_s_p_strb,
    output logic [ADDR_W-1:0]              o_s_p_addr,
    output logic [DATA_W-1:0]              o_s_p_wdata,
    output logic                           o_s_p_ce,
    output logic                           o_s_p_we,
    input  logic                           i_s_p_rdy,
    input  logic [DATA_W-1:0]              i_s_p_rdata,
    output logic [NUM_MST-1:0]             o_grant,
    output logic                           o_timeout
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [PTR_W-1:0]        ptr, ptr_nxt;
    logic [NUM_MST-1:0]      grant_nxt;
    logic                    s_sel_nxt, s_ce_nxt, s_we_nxt;
    logic [STRB_W-1:0]       s_strb_nxt;
    logic [ADDR_W-1:0]       s_addr_nxt;
    logic [DATA_W-1:0]       s_wdata_nxt;
    logic [NUM_MST-1:0]      m_rdy_nxt;
    logic [NUM_MST*DATA_W-1:0] m_rdata_nxt;
    logic                    timeout_nxt;

    logic [PTR_W-1:0]        win;
    logic [PTR_W-1:0]        cand;
    logic                    found;
    logic                    done;
    logic                    hang;
    logic [DATA_W-1:0]       done_data;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ptr_nxt     = ptr;
        grant_nxt   = o_grant;
        s_sel_nxt   = o_s_p_sel;
        s_ce_nxt    = o_s_p_ce;
        s_we_nxt    = o_s_p_we;
        s_strb_nxt  = o_s_p_strb;
        s_addr_nxt  = o_s_p_addr;
        s_wdata_nxt = o_s_p_wdata;
        m_rdy_nxt   = o_m_p_rdy;
        m_rdata_nxt = o_m_p_rdata;
        timeout_nxt = o_timeout;
        win         = ptr;
        cand        = ptr;
        found       = 1'b0;
        hang        = (TIMEOUT != 0) && (cnt == CNT_LAST);
        done        = i_s_p_rdy || hang;
        done_data   = i_s_p_rdy ? i_s_p_rdata : ERR_DATA;

        // Search starts just past the last winner, so the previous owner is considered last.
        for (int i = 1; i <= NUM_MST; i++) begin
            cand = PTR_W'((int'(ptr) + i) % NUM_MST);
            if (!found && i_m_p_sel[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    s_sel_nxt      = 1'b1;
                    s_we_nxt       = i_m_p_we[win];
                    s_strb_nxt     = i_m_p_strb[int'(win)*STRB_W +: STRB_W];
                    s_addr_nxt     = i_m_p_addr[int'(win)*ADDR_W +: ADDR_W];
                    s_wdata_nxt    = i_m_p_wdata[int'(win)*DATA_W +: DATA_W];
                    grant_nxt      = '0;
                    grant_nxt[win] = 1'b1;
                    ptr_nxt        = win;
                    state_nxt      = SETUP;
                end
            end
            SETUP: begin
                s_ce_nxt  = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    s_sel_nxt      = 1'b0;
                    s_ce_nxt       = 1'b0;
                    m_rdy_nxt[ptr] = 1'b1;
                    m_rdata_nxt[int'(ptr)*DATA_W +: DATA_W] = o_s_p_we ? '0 : done_data;
                    timeout_nxt    = !i_s_p_rdy;
                    state_nxt      = RESP;
                end else if (TIMEOUT != 0) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                m_rdy_nxt   = '0;
                m_rdata_nxt = '0;
                timeout_nxt = 1'b0;
                grant_nxt   = '0;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= PTR_W'(NUM_MST - 1);
            o_grant     <= '0;
            o_s_p_sel   <= 1'b0;
            o_s_p_ce    <= 1'b0;
            o_s_p_we    <= 1'b0;
            o_s_p_strb  <= '0;
            o_s_p_addr  <= '0;
            o_s_p_wdata <= '0;
            o_m_p_rdy   <= '0;
            o_m_p_rdata <= '0;
            o_timeout   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ptr         <= ptr_nxt;
            o_grant     <= grant_nxt;
            o_s_p_sel   <= s_sel_nxt;
            o_s_p_ce    <= s_ce_nxt;
            o_s_p_we    <= s_we_nxt;
            o_s_p_strb  <= s_strb_nxt;
            o_s_p_addr  <= s_addr_nxt;
            o_s_p_wdata <= s_wdata_nxt;
            o_m_p_rdy   <= m_rdy_nxt;
            o_m_p_rdata <= m_rdata_nxt;
            o_timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_ipsl_pcie_apb_arb_v1_0.sv
// Directed bench for the two-master APB arbiter with an 8-cycle hang timeout.
module tb_ipsl_pcie_apb_arb_v1_0;

    logic        clk;
    logic        i_rst_n;
    logic [1:0]  i_m_p_sel;
    logic [7:0]  i_m_p_strb;
    logic [31:0] i_m_p_addr;
    logic [63:0] i_m_p_wdata;
    logic [1:0]  i_m_p_ce;
    logic [1:0]  i_m_p_we;
    logic [1:0]  o_m_p_rdy;
    logic [63:0] o_m_p_rdata;
    logic        o_s_p_sel;
    logic [3:0]  o_s_p_strb;
    logic [15:0] o_s_p_addr;
    logic [31:0] o_s_p_wdata;
    logic        o_s_p_ce;
    logic        o_s_p_we;
    logic        i_s_p_rdy;
    logic [31:0] i_s_p_rdata;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int n_checks = 0;
    int n_errors = 0;

    ipsl_pcie_apb_arb_v1_0 #(
        .NUM_MST (2),
        .ADDR_W  (16),
        .DATA_W  (32),
        .TIMEOUT (8),
        .ERR_DATA(32'hFFFF_FFFF)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_m_p_sel   (i_m_p_sel),
        .i_m_p_strb  (i_m_p_strb),
        .i_m_p_addr  (i_m_p_addr),
        .i_m_p_wdata (i_m_p_wdata),
        .i_m_p_ce    (i_m_p_ce),
        .i_m_p_we    (i_m_p_we),
        .o_m_p_rdy   (o_m_p_rdy),
        .o_m_p_rdata (o_m_p_rdata),
        .o_s_p_sel   (o_s_p_sel),
        .o_s_p_strb  (o_s_p_strb),
        .o_s_p_addr  (o_s_p_addr),
        .o_s_p_wdata (o_s_p_wdata),
        .o_s_p_ce    (o_s_p_ce),
        .o_s_p_we    (o_s_p_we),
        .i_s_p_rdy   (i_s_p_rdy),
        .i_s_p_rdata (i_s_p_rdata),
        .o_grant     (o_grant),
        .o_timeout   (o_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transfer for master m and checks every phase. rdy_at is the ACCESS
    // cycle (1-based) in which the slave answers, 0 for never; exp_cyc is the ACCESS
    // cycle count until completion.
    task automatic run_xfer(input int m, input logic we, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input int rdy_at, input logic [31:0] s_rdata,
                            input int exp_cyc, input logic [31:0] exp_rdata,
                            input logic exp_to, input string tag);
        logic [1:0]  oh;
        logic [63:0] exp_vec;
        oh = 2'b01 << m;
        exp_vec = '0;
        exp_vec[m*32 +: 32] = exp_rdata;

        i_m_p_sel[m] = 1'b1;
        i_m_p_we[m]  = we;
        i_m_p_ce[m]  = 1'b0;
        i_m_p_addr[m*16 +: 16]  = addr;
        i_m_p_wdata[m*32 +: 32] = wdata;
        i_m_p_strb[m*4 +: 4]    = strb;
        tick();
        check({tag, "_sel"},   64'(o_s_p_sel),   64'(1'b1));
        check({tag, "_ce0"},   64'(o_s_p_ce),    64'(1'b0));
        check({tag, "_grant"}, 64'(o_grant),     64'(oh));
        check({tag, "_addr"},  64'(o_s_p_addr),  64'(addr));
        check({tag, "_wdata"}, 64'(o_s_p_wdata), 64'(wdata));
        check({tag, "_strb"},  64'(o_s_p_strb),  64'(strb));
        check({tag, "_we"},    64'(o_s_p_we),    64'(we));
        i_m_p_ce[m] = 1'b1;
        tick();
        check({tag, "_ce1"}, 64'(o_s_p_ce), 64'(1'b1));
        for (int c = 1; c <= exp_cyc; c++) begin
            check({tag, "_no_early_rdy"}, 64'(o_m_p_rdy), 64'(2'b00));
            if (c == rdy_at) begin
                i_s_p_rdy   = 1'b1;
                i_s_p_rdata = s_rdata;
            end
            tick();
            i_s_p_rdy   = 1'b0;
            i_s_p_rdata = 32'h0;
        end
        check({tag, "_rdy"},     64'(o_m_p_rdy), 64'(oh));
        check({tag, "_rdata"},   o_m_p_rdata,    exp_vec);
        check({tag, "_timeout"}, 64'(o_timeout), 64'(exp_to));
        check({tag, "_sel_off"}, 64'(o_s_p_sel), 64'(1'b0));
        check({tag, "_ce_off"},  64'(o_s_p_ce),  64'(1'b0));
        check({tag, "_grant_hold"}, 64'(o_grant), 64'(oh));
        i_m_p_sel[m] = 1'b0;
        i_m_p_ce[m]  = 1'b0;
        tick();
        check({tag, "_rdy_clr"},   64'(o_m_p_rdy),  64'(2'b00));
        check({tag, "_rdata_clr"}, o_m_p_rdata,     64'h0);
        check({tag, "_to_clr"},    64'(o_timeout),  64'(1'b0));
        check({tag, "_grant_clr"}, 64'(o_grant),    64'(2'b00));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sel"},   64'(o_s_p_sel),   64'h0);
        check({tag, "_ce"},    64'(o_s_p_ce),    64'h0);
        check({tag, "_grant"}, 64'(o_grant),     64'h0);
        check({tag, "_rdy"},   64'(o_m_p_rdy),   64'h0);
        check({tag, "_rdata"}, o_m_p_rdata,      64'h0);
        check({tag, "_to"},    64'(o_timeout),   64'h0);
        check({tag, "_addr"},  64'(o_s_p_addr),  64'h0);
        check({tag, "_wdata"}, 64'(o_s_p_wdata), 64'h0);
        check({tag, "_strb"},  64'(o_s_p_strb),  64'h0);
        check({tag, "_we"},    64'(o_s_p_we),    64'h0);
    endtask

    initial begin
        i_rst_n     = 1'b0;
        i_m_p_sel   = '0;
        i_m_p_strb  = '0;
        i_m_p_addr  = '0;
        i_m_p_wdata = '0;
        i_m_p_ce    = '0;
        i_m_p_we    = '0;
        i_s_p_rdy   = 1'b0;
        i_s_p_rdata = '0;
        tick();
        tick();
        check_all_zero("reset");
        i_rst_n = 1'b1;

        // Slave rdy while idle must be ignored.
        i_s_p_rdy   = 1'b1;
        i_s_p_rdata = 32'h1111_2222;
        tick();
        tick();
        check("idle_rdy_ignored", 64'(o_m_p_rdy), 64'h0);
        check("idle_no_sel",      64'(o_s_p_sel), 64'h0);
        i_s_p_rdy   = 1'b0;
        i_s_p_rdata = 32'h0;

        // 1: write from m0, slave answers in the 2nd ACCESS cycle; writes return 0.
        run_xfer(0, 1'b1, 16'h0010, 32'h1234_5678, 4'hF, 2, 32'hDEAD_BEEF,
                 2, 32'h0, 1'b0, "t1_wr");

        // 2: read from m1.
        run_xfer(1, 1'b0, 16'h0020, 32'h0, 4'h0, 1, 32'hCAFE_0001,
                 1, 32'hCAFE_0001, 1'b0, "t2_rd");

        // 3: both keep requesting; pointer sits on m1, so grants go 0,1,0,1.
        i_m_p_sel = 2'b11;
        run_xfer(0, 1'b1, 16'h0A00, 32'hA000_0000, 4'h3, 1, 32'h0, 1, 32'h0, 1'b0, "t3_a");
        i_m_p_sel = 2'b11;
        run_xfer(1, 1'b1, 16'h0B00, 32'hB000_0001, 4'hC, 1, 32'h0, 1, 32'h0, 1'b0, "t3_b");
        i_m_p_sel = 2'b11;
        run_xfer(0, 1'b0, 16'h0A04, 32'h0, 4'h0, 1, 32'h0A0A_0002, 1, 32'h0A0A_0002, 1'b0, "t3_c");
        i_m_p_sel = 2'b11;
        run_xfer(1, 1'b0, 16'h0B04, 32'h0, 4'h0, 1, 32'h0B0B_0003, 1, 32'h0B0B_0003, 1'b0, "t3_d");
        i_m_p_sel = 2'b00;

        // 4: slave never answers -> timeout after 8 ACCESS cycles with error data.
        run_xfer(0, 1'b0, 16'h0040, 32'h0, 4'hF, 0, 32'h0,
                 8, 32'hFFFF_FFFF, 1'b1, "t4_to");

        // 5: slave answers on the same cycle as the timeout compare; slave wins.
        run_xfer(1, 1'b0, 16'h0044, 32'h0, 4'hF, 8, 32'h5A5A_0005,
                 8, 32'h5A5A_0005, 1'b0, "t5_race");

        // 6: reset in ACCESS of an m0 transfer, then both request: m0 wins after reset.
        i_m_p_sel = 2'b01;
        i_m_p_we  = 2'b00;
        i_m_p_addr[15:0] = 16'h0060;
        tick();
        i_m_p_ce = 2'b01;
        tick();
        tick();
        check("t6_in_access", 64'(o_s_p_ce), 64'(1'b1));
        i_rst_n     = 1'b0;
        i_s_p_rdy   = 1'b1;
        i_s_p_rdata = 32'h7777_7777;
        i_m_p_sel   = 2'b00;
        i_m_p_ce    = 2'b00;
        tick();
        check_all_zero("t6_rst");
        i_s_p_rdy   = 1'b0;
        i_s_p_rdata = 32'h0;
        i_rst_n     = 1'b1;
        tick();
        check("t6_no_rdy", 64'(o_m_p_rdy), 64'h0);
        i_m_p_sel = 2'b11;
        run_xfer(0, 1'b1, 16'h0070, 32'h0000_0070, 4'h1, 1, 32'h0, 1, 32'h0, 1'b0, "t6_after");
        i_m_p_sel = 2'b00;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
